// File: rtl/rv_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle RV32I controller and its datapath:
// instruction fields and zero flag in, datapath steering and enables out.
interface rv_multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic       illegal_instr;
  logic [3:0] state;

  modport master (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr, state
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr, state
  );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Moore control FSM and ALU decoder for the multi-cycle RV32I core; outputs
// decode from the state register, only BRANCH's pc_write also sees zero/funct3.
module rv_multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rv_multicycle_ctrl_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR_ADR = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_e state_q, state_d;

  function automatic logic [3:0] func_decode(input logic [6:0] op,
                                             input logic [2:0] f3,
                                             input logic       f7b5);
    case (f3)
      3'b000:  func_decode = (op[5] && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  func_decode = ALU_SLL;
      3'b010:  func_decode = ALU_SLT;
      3'b011:  func_decode = ALU_SLTU;
      3'b100:  func_decode = ALU_XOR;
      3'b101:  func_decode = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  func_decode = ALU_OR;
      default: func_decode = ALU_AND;
    endcase
  endfunction

  function automatic logic [3:0] cmp_decode(input logic [2:0] f3);
    case (f3[2:1])
      2'b10:   cmp_decode = ALU_SLT;
      2'b11:   cmp_decode = ALU_SLTU;
      default: cmp_decode = ALU_SUB;
    endcase
  endfunction

  // beq/bge/bgeu want zero; bne/blt/bltu want !zero; 010/011 never branch.
  function automatic logic branch_taken(input logic [2:0] f3, input logic z);
    if (f3[2:1] == 2'b01) branch_taken = 1'b0;
    else if (f3[2])       branch_taken = f3[0] ? z : !z;
    else                  branch_taken = f3[0] ? !z : z;
  endfunction

  always_comb begin
    state_d               = S_FETCH;
    bus.pc_write          = 1'b0;
    bus.adr_src           = 1'b0;
    bus.mem_write         = 1'b0;
    bus.ir_write          = 1'b0;
    bus.reg_write         = 1'b0;
    bus.result_src        = 2'b00;
    bus.alu_src_a         = 2'b00;
    bus.alu_src_b         = 2'b00;
    bus.alu_control       = ALU_ADD;
    bus.illegal_instr     = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.ir_write   = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        bus.pc_write   = 1'b1;
        state_d        = S_DECODE;
      end
      S_DECODE: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR_ADR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default: begin
            state_d           = S_FETCH;
            bus.illegal_instr = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        state_d       = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.adr_src = 1'b1;
        state_d     = S_MEMWB;
      end
      S_MEMWB: begin
        bus.result_src = 2'b01;
        bus.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        bus.adr_src   = 1'b1;
        bus.mem_write = 1'b1;
      end
      S_EXECR: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_control = func_decode(bus.op, bus.funct3, bus.funct7b5);
        state_d         = S_ALUWB;
      end
      S_EXECI: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_src_b   = 2'b01;
        bus.alu_control = func_decode(bus.op, bus.funct3, bus.funct7b5);
        state_d         = S_ALUWB;
      end
      S_ALUWB: bus.reg_write = 1'b1;
      S_BRANCH: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_control = cmp_decode(bus.funct3);
        bus.pc_write    = branch_taken(bus.funct3, bus.zero);
      end
      S_JAL: begin
        // ALUOut already holds the target; this cycle forms the link value.
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.pc_write  = 1'b1;
        state_d       = S_ALUWB;
      end
      S_JALR_ADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        state_d       = S_JAL;
      end
      S_LUI: begin
        bus.alu_src_a = 2'b11;
        bus.alu_src_b = 2'b01;
        state_d       = S_ALUWB;
      end
      S_AUIPC: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        state_d       = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
    if (!rst_n) begin
      bus.pc_write      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.reg_write     = 1'b0;
      bus.illegal_instr = 1'b0;
    end
  end

  always_comb begin
    case (bus.op)
      OP_STORE:         bus.imm_src = 3'b001;
      OP_BRANCH:        bus.imm_src = 3'b010;
      OP_JAL:           bus.imm_src = 3'b011;
      OP_LUI, OP_AUIPC: bus.imm_src = 3'b100;
      default:          bus.imm_src = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= state_e'(RESET_STATE);
    else        state_q <= state_d;
  end

  assign bus.state = state_q;

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Moore-style control FSM plus ALU decoder for the multi-cycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over the shared ALU, PC, IR, ALUOut and register file.
- Drives the 4-bit ALU control encoding directly and resolves branches from the ALU zero flag.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7b5  in  1  IR[30].
- zero  in  1  ALU zero flag.
- pc_write  out  1  PC load enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  data memory write enable.
- ir_write  out  1  IR and OldPC load enable.
- reg_write  out  1  register file write enable.
- result_src  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUresult.
- alu_src_a  out  2  SrcA select: 00 = PC, 01 = OldPC, 10 = A (rs1), 11 = zero.
- alu_src_b  out  2  SrcB select: 00 = B (rs2), 01 = imm, 10 = constant 4.
- imm_src  out  3  immediate type: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- alu_control  out  4  ALU operation: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0101 SLT, 0110 SLTU, 0111 XOR, 1000 SRL, 1001 SRA, 1010 SLL.
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode.
- state  out  4  current state, for debug.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is synchronous and active-low.
- While rst_n = 0, the state register loads FETCH at the clock edge.
- While rst_n = 0, pc_write, mem_write, ir_write, reg_write and illegal_instr are forced to 0; the remaining outputs are don't-care.
- Reset mid-instruction aborts it. No write occurs in the cycle rst_n is sampled low.
- State encoding:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7
  - ALUWB 8, BRANCH 9, JAL 10, JALR_ADR 11, LUI 12, AUIPC 13
  - Codes 14 and 15 go to FETCH on the next edge, with all enables 0.
- Per-state outputs (unlisted enables are 0; unlisted selects are don't-care):
  - FETCH: adr_src 0, ir_write 1, src_a 00, src_b 10, ADD, result_src 10, pc_write 1. Next: DECODE.
  - DECODE: src_a 01, src_b 01, ADD (branch/JAL target into ALUOut). Next is chosen by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR_ADR
    - 0110111 → LUI
    - 0010111 → AUIPC
    - any other op → FETCH, with illegal_instr = 1 for this cycle only.
  - MEMADR: src_a 10, src_b 01, ADD. Next: MEMREAD if op[5] = 0, else MEMWRITE.
  - MEMREAD: adr_src 1, result_src 00. Next: MEMWB.
  - MEMWB: result_src 01, reg_write 1. Next: FETCH.
  - MEMWRITE: adr_src 1, result_src 00, mem_write 1. Next: FETCH.
  - EXECR: src_a 10, src_b 00, function decode. Next: ALUWB.
  - EXECI: src_a 10, src_b 01, function decode. Next: ALUWB.
  - ALUWB: result_src 00, reg_write 1. Next: FETCH.
  - BRANCH: src_a 10, src_b 00, compare decode, result_src 00, pc_write = taken. Next: FETCH.
  - JALR_ADR: src_a 10, src_b 01, ADD (target into ALUOut). Next: JAL.
  - JAL: src_a 01, src_b 10, ADD, result_src 00, pc_write 1. Next: ALUWB (rd ← OldPC+4).
  - LUI: src_a 11, src_b 01, ADD. Next: ALUWB.
  - AUIPC: src_a 01, src_b 01, ADD. Next: ALUWB.
- Function decode by funct3:
  - 000: SUB if op[5] & funct7b5, else ADD.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
  - 101: SRA if funct7b5, else SRL (I-type and R-type alike).
  - 110: OR. 111: AND.
- Compare decode by funct3:
  - 000/001: SUB.
  - 100/101: SLT.
  - 110/111: SLTU.
  - 010/011: SUB, with taken forced to 0.
- Branch taken:
  - beq = zero; bne = !zero.
  - blt/bltu = !zero (SLT result 1 means less).
  - bge/bgeu = zero.
- imm_src is combinational from op:
  - store → S; branch → B; jal → J; lui/auipc → U.
  - all others → I.
- Cycle counts:
  - load 5; store 4; R/I-type 4; branch 3.
  - jal 4; jalr 5; lui/auipc 4; illegal 2.
- Outputs are combinational from state. Only pc_write in BRANCH also depends on zero and funct3.

Test Plan:
- Reset: hold rst_n = 0 for 3 edges with op = 0110011 → state = 0, all enables 0. Release → FETCH then DECODE, with ir_write = 1 and pc_write = 1 in cycle 1.
- R-type sub (op 0110011, f3 000, f7b5 1) → states 0, 1, 6, 8, 0; alu_control 0001 in EXECR; reg_write 1 only in ALUWB. Repeat with op 0010011 → ADD (0000), since addi has no SUB.
- Load (0000011) → states 0, 1, 2, 3, 4; adr_src 1 in MEMREAD; result_src 01 with reg_write in MEMWB. Store (0100011) → mem_write 1 only in state 5; imm_src 001.
- Branches:
  - bne with zero = 0 → pc_write 1 in BRANCH; with zero = 1 → 0.
  - bgeu (f3 111) → alu_control 0110, pc_write = zero.
  - f3 010 → pc_write 0.
- srai (op 0010011, f3 101, f7b5 1) → 1001; srli → 1000. jalr → states 0, 1, 11, 10, 8.
- Illegal op 1111111 → illegal_instr 1 for one cycle in DECODE, then FETCH. Assert rst_n = 0 during MEMWRITE → mem_write 0 that cycle, state 0 next.
